// File: rtl/apb_rr_master_pkg.sv
// Shared widths and FSM state encodings for the round-robin APB master.
package apb_rr_master_pkg;

  localparam int APB_ADDR_W = 3;
  localparam int APB_DATA_W = 16;

  typedef logic [1:0] apb_state_e;
  localparam apb_state_e IDLE   = 2'd0;
  localparam apb_state_e SETUP  = 2'd1;
  localparam apb_state_e ACCESS = 2'd2;

endpackage

// File: rtl/apb_rr_master_if.sv
// APB bus between the round-robin master and the register slave, with protocol checks.
interface apb_rr_master_if
  import apb_rr_master_pkg::*;
(
  input logic pclk,
  input logic preset_n
);

  logic [APB_ADDR_W-1:0] paddr;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic [APB_DATA_W-1:0] prdata;

  modport master (output paddr, psel, penable, pwrite, pwdata, input pready, prdata);
  modport slave  (input paddr, psel, penable, pwrite, pwdata, output pready, prdata);

  a_enable_has_sel: assert property (@(posedge pclk) disable iff (!preset_n)
    penable |-> psel);

  a_setup_to_access: assert property (@(posedge pclk) disable iff (!preset_n)
    ($past(psel) && !$past(penable)) |->
      (psel && penable && paddr == $past(paddr) && pwrite == $past(pwrite)
       && pwdata == $past(pwdata)));

  // A wait state may only be left by completing or aborting (psel drops).
  a_wait_stable: assert property (@(posedge pclk) disable iff (!preset_n)
    $past(psel && penable && !pready) |->
      (!psel || (penable && paddr == $past(paddr) && pwrite == $past(pwrite)
                 && pwdata == $past(pwdata))));

endinterface

// File: rtl/apb_rr_master_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
module apb_rr_master_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  logic [N-1:0]  eligible;
  logic [IW-1:0] idx;

  assign eligible = req & ~mask;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % 32'(N));
      if (!any && eligible[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master sharing one register slave between N_REQ requesters.
module apb_rr_master
  import apb_rr_master_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                        pclk,
  input  logic                        preset_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*APB_ADDR_W-1:0] req_addr,
  input  logic [N_REQ*APB_DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ack,
  output logic                        req_err,
  output logic [APB_DATA_W-1:0]       req_rdata,
  apb_rr_master_if.master             apb
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  apb_state_e            state;
  logic [N_REQ-1:0]      grant_q;
  logic [N_REQ-1:0]      mask;
  logic [N_REQ-1:0]      arb_grant;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         arb_idx;
  logic                  arb_any;
  logic [CW-1:0]         wait_cnt;
  logic                  done;
  logic                  timeout_hit;
  logic                  launch;
  logic [APB_ADDR_W-1:0] sel_addr;
  logic                  sel_write;
  logic [APB_DATA_W-1:0] sel_wdata;

  assign done        = (state == ACCESS) && apb.pready;
  assign timeout_hit = (TIMEOUT != 0) && (state == ACCESS) && !apb.pready
                       && (wait_cnt == WAIT_LAST);
  assign mask        = (state == ACCESS) ? grant_q : '0;
  assign launch      = arb_any && ((state == IDLE) || done);

  assign req_ack   = (done || timeout_hit) ? grant_q : '0;
  assign req_err   = timeout_hit;
  assign req_rdata = done ? apb.prdata : '0;

  apb_rr_master_rr_arbiter #(.N(N_REQ)) u_arb (
    .req       (req_valid),
    .mask      (mask),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_addr  = '0;
    sel_write = 1'b0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        sel_addr  = req_addr[i*APB_ADDR_W +: APB_ADDR_W];
        sel_write = req_write[i];
        sel_wdata = req_wdata[i*APB_DATA_W +: APB_DATA_W];
      end
    end
  end

  // Completion and a fresh grant share one edge, so back-to-back transfers keep psel high.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state       <= IDLE;
      grant_q     <= '0;
      ptr         <= '0;
      wait_cnt    <= '0;
      apb.psel    <= 1'b0;
      apb.penable <= 1'b0;
      apb.paddr   <= '0;
      apb.pwrite  <= 1'b0;
      apb.pwdata  <= '0;
    end else if (launch) begin
      state       <= SETUP;
      grant_q     <= arb_grant;
      ptr         <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
      wait_cnt    <= '0;
      apb.psel    <= 1'b1;
      apb.penable <= 1'b0;
      apb.paddr   <= sel_addr;
      apb.pwrite  <= sel_write;
      apb.pwdata  <= sel_write ? sel_wdata : '0;
    end else begin
      case (state)
        IDLE: ;
        SETUP: begin
          state       <= ACCESS;
          apb.penable <= 1'b1;
        end
        ACCESS: begin
          if (done || timeout_hit) begin
            state       <= IDLE;
            apb.psel    <= 1'b0;
            apb.penable <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          apb.psel    <= 1'b0;
          apb.penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: 2-requester instance with TIMEOUT=4, 4-requester soak instance.
module tb_apb_rr_master;

  logic pclk = 1'b0;
  logic preset_n = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec = 0;
  int n_bad = 0;

  apb_rr_master_if ifa (.pclk(pclk), .preset_n(preset_n));
  apb_rr_master_if ifb (.pclk(pclk), .preset_n(preset_n));

  logic [1:0]  va, wa, acka;
  logic [5:0]  addra;
  logic [31:0] wda;
  logic        erra;
  logic [15:0] rda;
  logic        pready_a;
  logic [15:0] regs [8];

  logic [3:0]  vb, wb, ackb;
  logic [11:0] addrb;
  logic [63:0] wdb;
  logic        errb;
  logic [15:0] rdb;
  logic        pready_b;

  assign ifa.pready = pready_a;
  assign ifa.prdata = regs[ifa.paddr];
  assign ifb.pready = pready_b;
  assign ifb.prdata = 16'hC0DE;

  always @(posedge pclk)
    if (ifa.psel && ifa.penable && ifa.pready && ifa.pwrite) regs[ifa.paddr] <= ifa.pwdata;

  apb_rr_master #(.N_REQ(2), .TIMEOUT(4)) dut_a (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(va), .req_write(wa), .req_addr(addra), .req_wdata(wda),
    .req_ack(acka), .req_err(erra), .req_rdata(rda), .apb(ifa.master)
  );

  apb_rr_master #(.N_REQ(4), .TIMEOUT(0)) dut_b (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(vb), .req_write(wb), .req_addr(addrb), .req_wdata(wdb),
    .req_ack(ackb), .req_err(errb), .req_rdata(rdb), .apb(ifb.master)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ack;
    int n_x;
    int ord_err;
    int expect_idx;
    int cnt [4];
    logic [3:0] exp_oh;

    va = '0; wa = '0; addra = '0; wda = '0; pready_a = 1'b1;
    vb = '0; wb = 4'hF; addrb = {3'd3, 3'd2, 3'd1, 3'd0};
    wdb = {16'h0003, 16'h0002, 16'h0001, 16'h0000}; pready_b = 1'b0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0;
    regs[5] = 16'h1234;
    regs[6] = 16'hBEEF;

    // Requests held during reset must not leak onto any output.
    va = 2'b11;
    repeat (3) step();
    check("reset_apb", {10'h0, ifa.psel, ifa.penable, ifa.pwrite, ifa.paddr, ifa.pwdata}, 32'h0);
    check("reset_req", {13'h0, acka, erra, rda}, 32'h0);
    va = '0;
    preset_n = 1'b1;
    step();

    // 1: single write, zero wait states
    wa = 2'b01; addra[2:0] = 3'h2; wda[15:0] = 16'hA5A5; va = 2'b01;
    step();
    check("t1_setup", {ifa.psel, ifa.penable, ifa.paddr, ifa.pwdata}, {11'h0, 2'b10, 3'h2, 16'hA5A5});
    check("t1_noack", acka, 2'b00);
    step();
    check("t1_access", {ifa.psel, ifa.penable}, 2'b11);
    check("t1_ack", {acka, erra}, {2'b01, 1'b0});
    va = '0;
    step();
    check("t1_idle", ifa.psel, 1'b0);
    check("t1_reg2", regs[2], 16'hA5A5);

    // 2: read with three wait states; pwdata must be zero on reads
    pready_a = 1'b0; wa = 2'b00; addra[5:3] = 3'h5; wda[31:16] = 16'hFFFF; va = 2'b10;
    step();
    check("t2_setup", {ifa.psel, ifa.penable, ifa.pwrite, ifa.paddr, ifa.pwdata},
          {10'h0, 3'b100, 3'h5, 16'h0});
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_wait", {ifa.psel, ifa.penable, ifa.paddr, acka}, {2'b11, 3'h5, 2'b00});
    end
    step();
    pready_a = 1'b1;
    #1;
    check("t2_ack", {acka, erra, rda}, {13'h0, 2'b10, 1'b0, 16'h1234});
    va = '0;
    step();
    check("t2_idle", ifa.psel, 1'b0);

    // 3: simultaneous requests from reset, back-to-back with no idle cycle
    preset_n = 1'b0; step(); preset_n = 1'b1; step();
    wa = 2'b11; addra = {3'h3, 3'h1}; wda = {16'h2222, 16'h1111}; pready_a = 1'b1; va = 2'b11;
    step();
    check("t3_setup0", {ifa.psel, ifa.penable, ifa.paddr}, {2'b10, 3'h1});
    step();
    check("t3_ack0", acka, 2'b01);
    addra[2:0] = 3'h4; wda[15:0] = 16'h3333;
    step();
    check("t3_setup1", {ifa.psel, ifa.penable, ifa.paddr}, {2'b10, 3'h3});
    step();
    check("t3_ack1", acka, 2'b10);
    va = 2'b01;
    step();
    check("t3_setup0b", {ifa.psel, ifa.penable, ifa.paddr}, {2'b10, 3'h4});
    step();
    check("t3_ack0b", acka, 2'b01);
    va = '0;
    step();
    check("t3_idle", ifa.psel, 1'b0);
    check("t3_regs13", {regs[3], regs[1]}, {16'h2222, 16'h1111});
    check("t3_reg4", regs[4], 16'h3333);

    // 4: timeout with pready stuck low, then a normal transfer
    pready_a = 1'b0; wa = 2'b00; addra[2:0] = 3'h6; va = 2'b01;
    step();
    check("t4_setup", {ifa.psel, ifa.penable, ifa.paddr}, {2'b10, 3'h6});
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_wait", {acka, erra}, 3'b000);
    end
    step();
    check("t4_abort", {acka, erra, rda}, {13'h0, 2'b01, 1'b1, 16'h0});
    va = '0;
    step();
    check("t4_idle", {ifa.psel, ifa.penable}, 2'b00);
    pready_a = 1'b1; addra[5:3] = 3'h5; va = 2'b10;
    step();
    step();
    check("t4_recover", {acka, erra, rda}, {13'h0, 2'b10, 1'b0, 16'h1234});
    va = '0;
    step();

    // 5: asynchronous reset in the middle of ACCESS
    pready_a = 1'b0; wa = 2'b10; addra[5:3] = 3'h7; wda[31:16] = 16'h7777; va = 2'b10;
    step();
    step();
    check("t5_in_access", {ifa.psel, ifa.penable}, 2'b11);
    #2 preset_n = 1'b0;
    #1;
    check("t5_async", {ifa.psel, ifa.penable, ifa.paddr, acka}, 7'h0);
    step();
    step();
    check("t5_hold", acka, 2'b00);
    preset_n = 1'b1; pready_a = 1'b1; n_ack = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (acka != 2'b00) begin
        n_ack++;
        va = '0;
      end
    end
    check("t5_acks", n_ack, 1);
    check("t5_reg7", regs[7], 16'h7777);

    // 6: fairness soak on the 4-requester instance with random pready
    n_x = 0; ord_err = 0; expect_idx = 0;
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    vb = 4'hF;
    for (int c = 0; c < 5000 && n_x < 400; c++) begin
      step();
      pready_b = 1'($urandom_range(0, 1));
      #1;
      if (ackb != 4'h0) begin
        exp_oh = 4'b0001 << expect_idx;
        if (ackb != exp_oh || errb) ord_err++;
        for (int k = 0; k < 4; k++) if (ackb[k]) cnt[k]++;
        expect_idx = (expect_idx + 1) % 4;
        n_x++;
      end
    end
    vb = '0;
    check("t6_transfers", n_x, 400);
    check("t6_order", ord_err, 0);
    for (int k = 0; k < 4; k++) check("t6_count", cnt[k], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
